// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: issues one M-extension op to the muldiv unit, tracks RAW/WAW hazards and writes back the result
module muldiv_issue_ctrl #(
    parameter int XLEN = 32,
    parameter int LAT  = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            id_valid_i,
    input  logic            id_is_muldiv_i,
    input  logic [2:0]      id_funct3_i,
    input  logic [4:0]      id_rd_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic [XLEN-1:0] id_op_a_i,
    input  logic [XLEN-1:0] id_op_b_i,
    input  logic            flush_i,
    output logic            id_ready_o,
    output logic            stall_o,
    output logic            md_issue_o,
    output logic [XLEN-1:0] md_op_a_o,
    output logic [XLEN-1:0] md_op_b_o,
    output logic [2:0]      md_funct3_o,
    input  logic            md_valid_i,
    input  logic [XLEN-1:0] md_result_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    input  logic            wb_ready_i,
    output logic            err_o
);
    typedef enum logic [1:0] {IDLE, BUSY, WB, DRAIN} state_t;
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              err_q, err_d;
    logic              accept;
    logic [4:0]        busy_rd;
    // next-state: cnt counts down to the expected md_valid_i cycle (cnt==1), cnt==0 without result is a timeout
    always_comb begin
        accept  = (state_q == IDLE) & id_valid_i & id_is_muldiv_i & ~flush_i;
        state_d = state_q;
        cnt_d   = accept ? 3'(LAT) : (cnt_q != 3'd0 ? cnt_q - 3'd1 : 3'd0);
        rd_d    = accept ? id_rd_i : rd_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                err_d   = err_q | md_valid_i;
                state_d = accept ? BUSY : IDLE;
            end
            BUSY: begin
                if (md_valid_i) begin
                    res_d   = md_result_i;
                    err_d   = err_q | (cnt_q != 3'd1);
                    state_d = (flush_i || rd_q == 5'd0) ? IDLE : WB;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end else if (cnt_q == 3'd0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WB: begin
                err_d   = err_q | md_valid_i;
                state_d = (flush_i || wb_ready_i) ? IDLE : WB;
            end
            DRAIN: begin
                if (md_valid_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rd_q    <= 5'd0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end
    // outputs: issue path is combinational from decode, stall compares sources and rd against the in-flight rd
    always_comb begin
        id_ready_o  = state_q == IDLE;
        md_issue_o  = accept;
        md_op_a_o   = accept ? id_op_a_i : '0;
        md_op_b_o   = accept ? id_op_b_i : '0;
        md_funct3_o = accept ? id_funct3_i : 3'd0;
        busy_rd     = (state_q == BUSY || state_q == WB) ? rd_q : 5'd0;
        stall_o     = id_valid_i & ((id_is_muldiv_i & ~id_ready_o) |
                      ((busy_rd != 5'd0) & ((id_rs1_used_i & (id_rs1_i == busy_rd)) |
                                            (id_rs2_used_i & (id_rs2_i == busy_rd)) |
                                            (id_rd_i == busy_rd))));
        wb_valid_o  = state_q == WB;
        wb_rd_o     = wb_valid_o ? rd_q : 5'd0;
        wb_data_o   = wb_valid_o ? res_q : '0;
        err_o       = err_q;
    end
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb_muldiv_issue_ctrl: directed checks of issue, hazard, writeback, flush and protocol-error behaviour at LAT=1
module tb_muldiv_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_is_muldiv, id_rs1_used, id_rs2_used, flush;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [31:0] id_op_a, id_op_b;
    logic        id_ready, stall, md_issue;
    logic [31:0] md_op_a, md_op_b;
    logic [2:0]  md_funct3;
    logic        md_valid;
    logic [31:0] md_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready, err;
    int          checks = 0;
    int          errors = 0;

    muldiv_issue_ctrl #(.XLEN(32), .LAT(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_valid_i(id_valid), .id_is_muldiv_i(id_is_muldiv), .id_funct3_i(id_funct3),
        .id_rd_i(id_rd), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_op_a_i(id_op_a), .id_op_b_i(id_op_b), .flush_i(flush),
        .id_ready_o(id_ready), .stall_o(stall), .md_issue_o(md_issue),
        .md_op_a_o(md_op_a), .md_op_b_o(md_op_b), .md_funct3_o(md_funct3),
        .md_valid_i(md_valid), .md_result_i(md_result),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .wb_ready_i(wb_ready), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        id_valid = 1; id_is_muldiv = 1; id_rd = rd; id_funct3 = f3; id_op_a = a; id_op_b = b;
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    endtask

    task automatic idle_dec;
        id_valid = 0; id_is_muldiv = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_op_a = 0; id_op_b = 0; id_funct3 = 0;
    endtask

    task automatic do_reset;
        rst_n = 0;
        #12;
        rst_n = 1;
        tick;
    endtask

    initial begin
        idle_dec; flush = 0; md_valid = 0; md_result = 0; wb_ready = 1; rst_n = 0;
        #3;
        chk("rst_ready", 32'(id_ready), 1); chk("rst_stall", 32'(stall), 0);
        chk("rst_issue", 32'(md_issue), 0); chk("rst_wbv", 32'(wb_valid), 0);
        chk("rst_err", 32'(err), 0); chk("rst_wbrd", 32'(wb_rd), 0);
        @(negedge clk); rst_n = 1; tick;

        // basic MUL 3*7 -> rd 5
        issue(5, 3'd0, 3, 7); settle;
        chk("t1_issue", 32'(md_issue), 1); chk("t1_opa", md_op_a, 3);
        chk("t1_opb", md_op_b, 7); chk("t1_f3", 32'(md_funct3), 0);
        tick;
        idle_dec; md_valid = 1; md_result = 21; settle;
        chk("t1_issue_off", 32'(md_issue), 0); chk("t1_opa_off", md_op_a, 0);
        chk("t1_busy_rdy", 32'(id_ready), 0); chk("t1_busy_wbv", 32'(wb_valid), 0);
        tick;
        md_valid = 0; settle;
        chk("t1_wbv", 32'(wb_valid), 1); chk("t1_wbrd", 32'(wb_rd), 5); chk("t1_wbdata", wb_data, 21);
        tick;
        chk("t1_idle_rdy", 32'(id_ready), 1); chk("t1_idle_wbv", 32'(wb_valid), 0);

        // DIV rd 9 followed by dependent ADD
        issue(9, 3'd4, 100, 7); tick;
        md_valid = 1; md_result = 14;
        idle_dec; id_valid = 1; id_rs1 = 9; id_rs1_used = 1; id_rd = 1; id_rs2 = 2; settle;
        chk("t2_raw_rs1", 32'(stall), 1);
        id_rs1 = 3; id_rs2 = 9; id_rs2_used = 0; settle;
        chk("t2_rs2_unused", 32'(stall), 0);
        id_rs2_used = 1; settle;
        chk("t2_raw_rs2", 32'(stall), 1);
        id_rs2_used = 0; id_rd = 9; settle;
        chk("t2_waw", 32'(stall), 1);
        id_rd = 4; id_is_muldiv = 1; settle;
        chk("t2_md_stall", 32'(stall), 1); chk("t2_md_rdy", 32'(id_ready), 0);
        chk("t2_md_noissue", 32'(md_issue), 0);
        id_is_muldiv = 0; id_rs1 = 9; id_rd = 1;
        tick;
        md_valid = 0; settle;
        chk("t2_wb_stall", 32'(stall), 1); chk("t2_wbrd", 32'(wb_rd), 9);
        tick;
        chk("t2_after_stall", 32'(stall), 0);
        idle_dec;

        // writeback backpressure
        issue(7, 3'd1, 1, 2); tick;
        idle_dec; md_valid = 1; md_result = 32'h1234; wb_ready = 0; tick;
        md_valid = 0;
        for (int i = 0; i < 4; i++) begin
            settle;
            chk("t3_hold_v", 32'(wb_valid), 1); chk("t3_hold_rd", 32'(wb_rd), 7);
            chk("t3_hold_d", wb_data, 32'h1234);
            tick;
        end
        wb_ready = 1; settle;
        chk("t3_hs_v", 32'(wb_valid), 1);
        tick;
        chk("t3_nodup", 32'(wb_valid), 0); chk("t3_rdy", 32'(id_ready), 1);

        // flush the cycle after accept, result arrives same cycle
        issue(6, 3'd0, 5, 5); tick;
        idle_dec; flush = 1; md_valid = 1; md_result = 99; tick;
        flush = 0; md_valid = 0; settle;
        chk("t4_wbv", 32'(wb_valid), 0); chk("t4_rdy", 32'(id_ready), 1); chk("t4_err", 32'(err), 0);

        // flush in WB drops the pending writeback
        issue(10, 3'd0, 2, 2); tick;
        idle_dec; md_valid = 1; md_result = 4; wb_ready = 0; tick;
        md_valid = 0; flush = 1; settle;
        chk("t4b_wbv", 32'(wb_valid), 1);
        tick;
        flush = 0; wb_ready = 1; settle;
        chk("t4b_drop", 32'(wb_valid), 0); chk("t4b_rdy", 32'(id_ready), 1);

        // rd=0 MULHU: no writeback
        issue(0, 3'd3, 32'hffff_ffff, 2); tick;
        idle_dec; md_valid = 1; md_result = 1; tick;
        md_valid = 0; settle;
        chk("t5_wbv", 32'(wb_valid), 0); chk("t5_rdy", 32'(id_ready), 1); chk("t5_err", 32'(err), 0);

        // withheld result -> timeout at T+LAT+2
        issue(8, 3'd0, 1, 1); tick;
        idle_dec; settle;
        chk("t6_err_t1", 32'(err), 0);
        tick;
        chk("t6_err_t2", 32'(err), 0); chk("t6_rdy_t2", 32'(id_ready), 0);
        tick;
        chk("t6_err_t3", 32'(err), 1); chk("t6_rdy_t3", 32'(id_ready), 1); chk("t6_wbv", 32'(wb_valid), 0);

        do_reset;
        chk("t7_err_clr", 32'(err), 0);

        // flush without result -> DRAIN then timeout
        issue(11, 3'd0, 1, 1); tick;
        idle_dec; flush = 1; tick;
        flush = 0; settle;
        chk("t7_drain_rdy", 32'(id_ready), 0); chk("t7_drain_err", 32'(err), 0);
        tick;
        chk("t7_drain_to", 32'(err), 1); chk("t7_drain_idle", 32'(id_ready), 1);
        chk("t7_drain_wbv", 32'(wb_valid), 0);

        do_reset;
        // spurious md_valid in IDLE
        md_valid = 1; tick;
        md_valid = 0; settle;
        chk("t8_spur_err", 32'(err), 1);

        // reset mid-BUSY
        issue(12, 3'd0, 4, 4); tick;
        idle_dec; rst_n = 0; #2;
        chk("t9_rdy", 32'(id_ready), 1); chk("t9_err", 32'(err), 0);
        chk("t9_wbv", 32'(wb_valid), 0); chk("t9_issue", 32'(md_issue), 0);
        rst_n = 1; tick; tick;
        chk("t9_nowb", 32'(wb_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
